// File: rtl/visitor_display_scan.sv
// rtl/visitor_display_scan.sv - 4-digit 7-segment scan controller with refresh divider, leading-zero blanking and enable.
// Optional anode dimming PWM is compiled in with VISITOR_DISPLAY_DIM_EN.
module visitor_display_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
`ifdef VISITOR_DISPLAY_DIM_EN
    input  logic [3:0] duty,
`endif
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int DW = $clog2(REFRESH_DIV + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);

    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_idx;
    logic [1:0]    r_sel;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_tick;
    logic [3:0]    w_dig;
    logic          w_blanked;
    logic          w_show;
    logic          w_an_on;
    logic [6:0]    w_seg_dec;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b0111111;
        endcase
    endfunction

    assign w_tick = en && (r_div_cnt == DIV_MAX);

    always_comb begin
        w_dig     = dig0;
        w_blanked = 1'b0;
        case (r_idx)
            2'd0: begin
                w_dig     = dig0;
                w_blanked = 1'b0;
            end
            2'd1: begin
                w_dig     = dig1;
                w_blanked = blank_lz && (dig3 == 4'd0) && (dig2 == 4'd0) && (dig1 == 4'd0);
            end
            2'd2: begin
                w_dig     = dig2;
                w_blanked = blank_lz && (dig3 == 4'd0) && (dig2 == 4'd0);
            end
            default: begin
                w_dig     = dig3;
                w_blanked = blank_lz && (dig3 == 4'd0);
            end
        endcase
    end

    assign w_show    = en && !w_blanked;
    assign w_seg_dec = f_decode(w_dig);

`ifdef VISITOR_DISPLAY_DIM_EN
    logic [3:0] r_pwm_cnt;

    // Free-running so the dimming phase is independent of scan enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_an_on = w_show && (r_pwm_cnt < duty);
`else
    assign w_an_on = w_show;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (en) begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_ONE;
            end
        end
    end

    // Outputs are loaded from the pre-update idx so sel, an and seg always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 2'b00;
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else begin
            r_sel <= r_idx;
            r_an  <= w_an_on ? ~(4'b0001 << r_idx) : 4'b1111;
            r_seg <= w_show ? w_seg_dec : 7'b1111111;
        end
    end

    assign sel = r_sel;
    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_visitor_display_scan.sv
// tb/tb_visitor_display_scan.sv - directed self-checking bench for visitor_display_scan.
// Dimming checks run instead of the scan checks when VISITOR_DISPLAY_DIM_EN is defined.
module tb_visitor_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       blank_lz = 1'b0;
    logic [3:0] dig0 = 4'd1;
    logic [3:0] dig1 = 4'd2;
    logic [3:0] dig2 = 4'd3;
    logic [3:0] dig3 = 4'd4;
    logic [1:0] sel, f_sel;
    logic [3:0] an, f_an;
    logic [6:0] seg, f_seg;
`ifdef VISITOR_DISPLAY_DIM_EN
    logic [3:0] duty = 4'd0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    visitor_display_scan #(.REFRESH_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
`ifdef VISITOR_DISPLAY_DIM_EN
        .duty(duty),
`endif
        .sel(sel), .an(an), .seg(seg)
    );

    visitor_display_scan #(.REFRESH_DIV(1)) u_fast (
        .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
`ifdef VISITOR_DISPLAY_DIM_EN
        .duty(duty),
`endif
        .sel(f_sel), .an(f_an), .seg(f_seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Expected an/seg for digit k live at an_exp[4k+:4] and seg_exp[7k+:7].
    task automatic scan_frame(input string tag, input logic [15:0] an_exp, input logic [27:0] seg_exp);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check({tag, "_sel"}, 32'(sel), 32'(k));
                check({tag, "_an"}, 32'(an), 32'(an_exp[4*k +: 4]));
                check({tag, "_seg"}, 32'(seg), 32'(seg_exp[7*k +: 7]));
            end
        end
    endtask

    initial begin
`ifdef VISITOR_DISPLAY_DIM_EN
        int low_cnt;
        restart();
        duty = 4'd4;
        low_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (an != 4'b1111) low_cnt++;
            check("dim_seg_on", 32'(seg == 7'b1111111), 32'd0);
        end
        check("dim_duty4", 32'(low_cnt), 32'd4);
        duty = 4'd0;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            check("dim_duty0_an", 32'(an), 32'hf);
        end
`else
        // Reset held two cycles.
        step();
        step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_an", 32'(an), 32'hf);
        check("rst_seg", 32'(seg), 32'h7f);
        rst = 1'b0;
        scan_frame("t1", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001});
        step();
        check("t1_wrap_sel", 32'(sel), 32'd0);

        // Leading-zero blanking on, then off.
        blank_lz = 1'b1;
        dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd7; dig0 = 4'd0;
        restart();
        scan_frame("t2b", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                   {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000});
        blank_lz = 1'b0;
        restart();
        scan_frame("t2n", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000});

        // Enable dropped two cycles into the digit-2 window.
        dig3 = 4'd4; dig2 = 4'd3; dig1 = 4'd2; dig0 = 4'd1;
        restart();
        for (int i = 0; i < 10; i++) step();
        check("t3_pre_sel", 32'(sel), 32'd2);
        check("t3_pre_an", 32'(an), 32'hb);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_off_an", 32'(an), 32'hf);
            check("t3_off_seg", 32'(seg), 32'h7f);
            check("t3_off_sel", 32'(sel), 32'd2);
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_res_sel", 32'(sel), 32'd2);
            check("t3_res_an", 32'(an), 32'hb);
            check("t3_res_seg", 32'(seg), 32'h30);
        end
        step();
        check("t3_next_sel", 32'(sel), 32'd3);
        check("t3_next_an", 32'(an), 32'h7);

        // One-cycle reset while idx=3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_sel", 32'(sel), 32'd0);
        check("t4_an", 32'(an), 32'hf);
        check("t4_seg", 32'(seg), 32'h7f);
        step();
        check("t4_d0_an", 32'(an), 32'he);
        check("t4_d0_seg", 32'(seg), 32'h79);
        for (int i = 0; i < 3; i++) step();
        check("t4_win_sel", 32'(sel), 32'd0);
        step();
        check("t4_next_sel", 32'(sel), 32'd1);

        // Non-BCD dash, and REFRESH_DIV=1 scanning every cycle.
        dig0 = 4'hC;
        restart();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_fast_sel", 32'(f_sel), 32'(i % 4));
            if (i == 0) begin
                check("t5_dash_seg", 32'(seg), 32'h3f);
                check("t5_dash_an", 32'(an), 32'he);
                check("t5_fast_seg", 32'(f_seg), 32'h3f);
            end
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
